trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Machine-mode trap controller placed between the system execution unit and the CSR file. It owns the CSR file's single write port and the front-end redirect port. In normal operation it forwards the system unit's CSR writes and `mret`/`sret` redirects. On an exception or an accepted interrupt it runs a fixed multi-cycle sequence: write `mepc`, then `mcause`, then `mstatus`, then redirect to the trap vector.

## Interface
Parameters: none (XLEN fixed at 64; CSR addresses fixed: mepc 0x341, mcause 0x342, mstatus 0x300).

- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- io_exu_valid  in  1  system-unit result valid this cycle
- io_pc  in  64  PC of the instruction currently presented (valid with io_exu_valid or io_irq_valid)
- io_csr_is_w  in  1  system unit requests CSR write
- io_result_csr_addr  in  12  system-unit CSR write address
- io_result_csr_data  in  64  system-unit CSR write data
- io_is_except  in  1  ecall/ebreak from system unit (already qualified by its valid)
- io_exception  in  6  exception cause code
- io_valid_next_pc  in  1  xRET redirect request
- io_next_pc  in  64  xRET target
- io_irq_valid  in  1  interrupt pending, already masked by mie/mstatus.MIE; level, held by source until taken
- io_irq_cause  in  6  interrupt cause code
- io_mtvec  in  64  current mtvec
- io_mstatus  in  64  current mstatus
- io_csr_wen  out  1  CSR write enable
- io_csr_waddr  out  12  CSR write address
- io_csr_wdata  out  64  CSR write data
- io_redirect_valid  out  1  front-end redirect
- io_redirect_pc  out  64  redirect target
- io_busy  out  1  pipeline must hold; no new instruction may be presented

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT. Reset state is IDLE.
- Priority in IDLE: exception (io_exu_valid & io_is_except) > interrupt (io_irq_valid) > normal CSR write / xRET.
- Trap accept (IDLE, exception or interrupt):
  - Latch pc_q = io_pc, cause_q = exception ? io_exception : io_irq_cause, intr_q = !exception, mstatus_q = io_mstatus, mtvec_q = io_mtvec.
  - Go to W_MEPC.
  - Suppress that cycle's system-unit CSR write and redirect; the interrupted instruction does not commit.
- W_MEPC: wen=1, waddr=0x341, wdata=pc_q with bits [1:0] cleared. Next state W_MCAUSE.
- W_MCAUSE: wen=1, waddr=0x342, wdata={intr_q, 57'b0, cause_q}. Next state W_MSTATUS.
- W_MSTATUS: wen=1, waddr=0x300. wdata = (mstatus_q & ~0x1888) | (mstatus_q[3] << 7) | 0x1800, i.e. MPIE←MIE, MIE←0, MPP←3. Next state REDIRECT.
- REDIRECT: redirect_valid=1, wen=0. Next state IDLE.
  - Target when mtvec_q[1:0]==1 and intr_q: {mtvec_q[63:2],2'b0} + (cause_q << 2).
  - Target otherwise: {mtvec_q[63:2],2'b0]}. Modes 2 and 3 are treated as direct.
- IDLE pass-through, no trap:
  - wen = io_exu_valid & io_csr_is_w; waddr/wdata come from io_result_csr_*.
  - redirect_valid = io_exu_valid & io_valid_next_pc; redirect_pc = io_next_pc.
  - Combinational, zero latency.
- io_busy = (state != IDLE) | trap accept this cycle.
- Exception together with io_valid_next_pc: exception wins and the xRET redirect is dropped.
- Exception together with interrupt: exception taken. The interrupt stays pending at the source and is taken at the earliest IDLE cycle after the sequence.
- io_irq_valid and io_exu_* are ignored outside IDLE.

## Timing
- Exception/interrupt accepted at cycle T:
  - mepc write at T+1, mcause at T+2, mstatus at T+3.
  - redirect at T+4.
  - IDLE at T+5; a new trap may be accepted in T+5.
- io_busy is high T..T+4.
- All addresses are 12-bit; all data is 64-bit. Vector add wraps modulo 2^64.
- Reset:
  - While reset is high, all outputs are 0.
  - Reset at any edge forces IDLE; no remaining writes or redirect from an interrupted sequence are issued.
  - Latched registers reset to 0.
- Exactly one of io_csr_wen / io_redirect_valid is high in any sequence state. In IDLE both may be high together (xRET mstatus write plus redirect).

## Test plan
- ecall at io_pc=0x8000_0104, io_exception=11, mtvec=0x8000_1000, mstatus=0x8:
  - T+1: wen, 0x341, 0x8000_0104.
  - T+2: 0x342, 0xB.
  - T+3: 0x300, 0x1880.
  - T+4: redirect to 0x8000_1000.
  - io_busy high for 5 cycles.
- Timer interrupt, cause 7, mtvec=0x8000_1001, pc=0x8000_0200:
  - mcause = 0x8000_0000_0000_0007.
  - Redirect to 0x8000_101C.
- CSRRW in IDLE (addr 0x305, data 0x1234) plus mret with io_next_pc=0x8000_0300:
  - Same-cycle wen with 0x305/0x1234.
  - Later mret cycle: wen to 0x300 and redirect to 0x8000_0300 in the same cycle.
  - io_busy stays 0.
- ebreak and io_irq_valid asserted together:
  - mcause=3 with bit 63 clear.
  - Interrupt held; its sequence starts at T+5 with mcause bit 63 set.
- Reset asserted at T+2 of a trap:
  - No mcause/mstatus write and no redirect.
  - All outputs 0 while reset is high.
  - IDLE after release; a CSR write is then forwarded in the same cycle.
- Trap at io_pc=0x8000_0106 (misaligned low bits): mepc written 0x8000_0104.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap controller sitting between the system
// execution unit and the CSR file. It owns the CSR write port and the
// front-end redirect port. In IDLE it forwards system-unit CSR writes and
// xRET redirects with no added latency. A trap runs a fixed sequence:
// mepc, mcause, mstatus, then a redirect to the trap vector.
module trap_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_exu_valid,
    input  logic [63:0] io_pc,
    input  logic        io_csr_is_w,
    input  logic [11:0] io_result_csr_addr,
    input  logic [63:0] io_result_csr_data,
    input  logic        io_is_except,
    input  logic [5:0]  io_exception,
    input  logic        io_valid_next_pc,
    input  logic [63:0] io_next_pc,
    input  logic        io_irq_valid,
    input  logic [5:0]  io_irq_cause,
    input  logic [63:0] io_mtvec,
    input  logic [63:0] io_mstatus,
    output logic        io_csr_wen,
    output logic [11:0] io_csr_waddr,
    output logic [63:0] io_csr_wdata,
    output logic        io_redirect_valid,
    output logic [63:0] io_redirect_pc,
    output logic        io_busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_W_MEPC    = 3'd1;
    localparam logic [2:0] S_W_MCAUSE  = 3'd2;
    localparam logic [2:0] S_W_MSTATUS = 3'd3;
    localparam logic [2:0] S_REDIRECT  = 3'd4;

    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;

    // MIE (bit 3), MPIE (bit 7) and MPP (bits 12:11).
    localparam logic [63:0] MSTATUS_TRAP_MASK = 64'h0000_0000_0000_1888;
    localparam logic [63:0] MSTATUS_MPP_M     = 64'h0000_0000_0000_1800;

    logic [2:0]  r_state;
    logic [63:0] r_pc;
    logic [5:0]  r_cause;
    logic        r_intr;
    logic [63:0] r_mstatus;
    logic [63:0] r_mtvec;

    logic        w_except;
    logic        w_trap_accept;
    logic [63:0] w_mepc_data;
    logic [63:0] w_mcause_data;
    logic [63:0] w_mstatus_data;
    logic [63:0] w_vec_base;
    logic [63:0] w_vec_offset;
    logic [63:0] w_vec_target;

    // Exceptions outrank interrupts; both are only looked at in IDLE.
    assign w_except      = io_exu_valid & io_is_except;
    assign w_trap_accept = (r_state == S_IDLE) & (w_except | io_irq_valid);

    // Values written by the sequence, derived from the snapshot taken at accept.
    assign w_mepc_data    = {r_pc[63:2], 2'b00};
    assign w_mcause_data  = {r_intr, 57'd0, r_cause};
    assign w_mstatus_data = (r_mstatus & ~MSTATUS_TRAP_MASK)
                          | {56'd0, r_mstatus[3], 7'd0}
                          | MSTATUS_MPP_M;

    // Vectored mode only applies to interrupts; modes 2 and 3 behave as direct.
    assign w_vec_base   = {r_mtvec[63:2], 2'b00};
    assign w_vec_offset = {56'd0, r_cause, 2'b00};
    assign w_vec_target = ((r_mtvec[1:0] == 2'b01) && r_intr)
                        ? (w_vec_base + w_vec_offset)
                        : w_vec_base;

    // Sequence state and the trap snapshot, captured in the accept cycle.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_cause   <= '0;
            r_intr    <= 1'b0;
            r_mstatus <= '0;
            r_mtvec   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trap_accept) begin
                        r_pc      <= io_pc;
                        r_cause   <= w_except ? io_exception : io_irq_cause;
                        r_intr    <= ~w_except;
                        r_mstatus <= io_mstatus;
                        r_mtvec   <= io_mtvec;
                        r_state   <= S_W_MEPC;
                    end
                end
                S_W_MEPC:    r_state <= S_W_MCAUSE;
                S_W_MCAUSE:  r_state <= S_W_MSTATUS;
                S_W_MSTATUS: r_state <= S_REDIRECT;
                S_REDIRECT:  r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    // Output mux: IDLE pass-through, or the current step of the trap sequence.
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        io_csr_wen        = 1'b0;
        io_csr_waddr      = '0;
        io_csr_wdata      = '0;
        io_redirect_valid = 1'b0;
        io_redirect_pc    = '0;
        io_busy           = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    io_busy = w_trap_accept;
                    // The trapping instruction does not commit its write/redirect.
                    if (!w_trap_accept) begin
                        io_csr_wen        = io_exu_valid & io_csr_is_w;
                        io_csr_waddr      = io_result_csr_addr;
                        io_csr_wdata      = io_result_csr_data;
                        io_redirect_valid = io_exu_valid & io_valid_next_pc;
                        io_redirect_pc    = io_next_pc;
                    end
                end
                S_W_MEPC: begin
                    io_busy      = 1'b1;
                    io_csr_wen   = 1'b1;
                    io_csr_waddr = CSR_MEPC;
                    io_csr_wdata = w_mepc_data;
                end
                S_W_MCAUSE: begin
                    io_busy      = 1'b1;
                    io_csr_wen   = 1'b1;
                    io_csr_waddr = CSR_MCAUSE;
                    io_csr_wdata = w_mcause_data;
                end
                S_W_MSTATUS: begin
                    io_busy      = 1'b1;
                    io_csr_wen   = 1'b1;
                    io_csr_waddr = CSR_MSTATUS;
                    io_csr_wdata = w_mstatus_data;
                end
                S_REDIRECT: begin
                    io_busy           = 1'b1;
                    io_redirect_valid = 1'b1;
                    io_redirect_pc    = w_vec_target;
                end
                default: begin
                    io_busy = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Testbench for trap_sequencer. Directed stimulus pushes hand-computed
// expected output events (with their expected cycle) into a scoreboard;
// a monitor pops and compares whenever the DUT asserts a write or redirect.
module tb_trap_sequencer;

    logic        clock;
    logic        reset;
    logic        io_exu_valid;
    logic [63:0] io_pc;
    logic        io_csr_is_w;
    logic [11:0] io_result_csr_addr;
    logic [63:0] io_result_csr_data;
    logic        io_is_except;
    logic [5:0]  io_exception;
    logic        io_valid_next_pc;
    logic [63:0] io_next_pc;
    logic        io_irq_valid;
    logic [5:0]  io_irq_cause;
    logic [63:0] io_mtvec;
    logic [63:0] io_mstatus;
    logic        io_csr_wen;
    logic [11:0] io_csr_waddr;
    logic [63:0] io_csr_wdata;
    logic        io_redirect_valid;
    logic [63:0] io_redirect_pc;
    logic        io_busy;

    typedef struct {
        int unsigned cyc;
        logic        wen;
        logic [11:0] waddr;
        logic [63:0] wdata;
        logic        rv;
        logic [63:0] rpc;
        logic        busy;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          n_tests;
    int          n_fail;
    int unsigned t0;

    trap_sequencer dut (
        .clock              (clock),
        .reset              (reset),
        .io_exu_valid       (io_exu_valid),
        .io_pc              (io_pc),
        .io_csr_is_w        (io_csr_is_w),
        .io_result_csr_addr (io_result_csr_addr),
        .io_result_csr_data (io_result_csr_data),
        .io_is_except       (io_is_except),
        .io_exception       (io_exception),
        .io_valid_next_pc   (io_valid_next_pc),
        .io_next_pc         (io_next_pc),
        .io_irq_valid       (io_irq_valid),
        .io_irq_cause       (io_irq_cause),
        .io_mtvec           (io_mtvec),
        .io_mstatus         (io_mstatus),
        .io_csr_wen         (io_csr_wen),
        .io_csr_waddr       (io_csr_waddr),
        .io_csr_wdata       (io_csr_wdata),
        .io_redirect_valid  (io_redirect_valid),
        .io_redirect_pc     (io_redirect_pc),
        .io_busy            (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle index: inputs driven just after a rising edge belong to cycle cyc.
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int unsigned c, input logic wen, input logic [11:0] a,
                           input logic [63:0] d, input logic rv, input logic [63:0] p,
                           input logic busy);
        exp_t e;
        e.cyc = c; e.wen = wen; e.waddr = a; e.wdata = d;
        e.rv = rv; e.rpc = p; e.busy = busy;
        sb.push_back(e);
    endtask

    // Full trap sequence accepted in cycle t, with hand-computed values.
    task automatic push_trap(input int unsigned t, input logic [63:0] mepc,
                             input logic [63:0] mcause, input logic [63:0] mstatus,
                             input logic [63:0] target);
        push_ev(t + 1, 1'b1, 12'h341, mepc,    1'b0, 64'd0,  1'b1);
        push_ev(t + 2, 1'b1, 12'h342, mcause,  1'b0, 64'd0,  1'b1);
        push_ev(t + 3, 1'b1, 12'h300, mstatus, 1'b0, 64'd0,  1'b1);
        push_ev(t + 4, 1'b0, 12'h000, 64'd0,   1'b1, target, 1'b1);
    endtask

    // Monitor: compare every DUT write/redirect against the scoreboard head.
    always @(negedge clock) begin
        if (io_csr_wen || io_redirect_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_wen", {63'd0, io_csr_wen}, 64'd0);
                check("unexpected_redirect", {63'd0, io_redirect_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ev_cycle", 64'(cyc), 64'(e.cyc));
                check("ev_wen", {63'd0, io_csr_wen}, {63'd0, e.wen});
                check("ev_redirect_valid", {63'd0, io_redirect_valid}, {63'd0, e.rv});
                if (e.wen) begin
                    check("ev_waddr", {52'd0, io_csr_waddr}, {52'd0, e.waddr});
                    check("ev_wdata", io_csr_wdata, e.wdata);
                end
                if (e.rv) check("ev_redirect_pc", io_redirect_pc, e.rpc);
                check("ev_busy", {63'd0, io_busy}, {63'd0, e.busy});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        io_exu_valid = 0; io_pc = '0; io_csr_is_w = 0;
        io_result_csr_addr = '0; io_result_csr_data = '0;
        io_is_except = 0; io_exception = '0;
        io_valid_next_pc = 0; io_next_pc = '0;
        io_irq_valid = 0; io_irq_cause = '0;
        io_mtvec = '0; io_mstatus = '0;
    endtask

    // Junk on the system-unit side; must be ignored while the sequence runs.
    task automatic garbage();
        io_exu_valid = 1; io_pc = 64'hFFFF_0000_1234_5677;
        io_csr_is_w = 1; io_result_csr_addr = 12'hABC;
        io_result_csr_data = 64'hDEAD_BEEF_CAFE_F00D;
        io_is_except = 1; io_exception = 6'h3F;
        io_valid_next_pc = 1; io_next_pc = 64'h1111_2222_3333_4444;
        io_mtvec = 64'h5555_5555_5555_5555; io_mstatus = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    // Cycles T+1..T+4 of a trap: busy high, system-unit inputs ignored.
    task automatic trap_body();
        @(negedge clock);
        check("busy_accept", {63'd0, io_busy}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            garbage();
            @(negedge clock);
            check("busy_seq", {63'd0, io_busy}, 64'd1);
        end
    endtask

    task automatic check_all_zero();
        @(negedge clock);
        check("rst_wen", {63'd0, io_csr_wen}, 64'd0);
        check("rst_waddr", {52'd0, io_csr_waddr}, 64'd0);
        check("rst_wdata", io_csr_wdata, 64'd0);
        check("rst_redirect_valid", {63'd0, io_redirect_valid}, 64'd0);
        check("rst_redirect_pc", io_redirect_pc, 64'd0);
        check("rst_busy", {63'd0, io_busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clr();
        reset = 1;

        // Reset: outputs zero even with a live CSR write + redirect presented.
        io_exu_valid = 1; io_csr_is_w = 1; io_result_csr_addr = 12'h305;
        io_result_csr_data = 64'h99; io_valid_next_pc = 1; io_next_pc = 64'h4000;
        io_irq_valid = 1;
        repeat (3) begin
            step();
            check_all_zero();
        end
        step();
        reset = 0;
        clr();

        // 1) ecall, direct mtvec, MIE=1.
        step();
        io_exu_valid = 1; io_is_except = 1; io_exception = 6'd11;
        io_pc = 64'h8000_0104; io_mtvec = 64'h8000_1000; io_mstatus = 64'h8;
        t0 = cyc;
        push_trap(t0, 64'h8000_0104, 64'hB, 64'h1880, 64'h8000_1000);
        trap_body();
        step();
        clr();
        @(negedge clock);
        check("busy_after_ecall", {63'd0, io_busy}, 64'd0);

        // 2) Timer interrupt, vectored mtvec, with a suppressed CSR write.
        step();
        io_irq_valid = 1; io_irq_cause = 6'd7;
        io_exu_valid = 1; io_csr_is_w = 1; io_result_csr_addr = 12'h305;
        io_result_csr_data = 64'h77;
        io_pc = 64'h8000_0200; io_mtvec = 64'h8000_1001; io_mstatus = 64'hA;
        t0 = cyc;
        push_trap(t0, 64'h8000_0200, 64'h8000_0000_0000_0007, 64'h1882, 64'h8000_101C);
        step();
        io_irq_valid = 0;
        garbage();
        for (int i = 0; i < 3; i++) begin
            step();
            garbage();
        end
        step();
        clr();
        @(negedge clock);
        check("busy_after_irq", {63'd0, io_busy}, 64'd0);

        // 3) CSRRW then mret: zero-latency pass-through, busy stays low.
        step();
        io_exu_valid = 1; io_csr_is_w = 1; io_result_csr_addr = 12'h305;
        io_result_csr_data = 64'h1234;
        push_ev(cyc, 1'b1, 12'h305, 64'h1234, 1'b0, 64'd0, 1'b0);
        step();
        io_result_csr_addr = 12'h300; io_result_csr_data = 64'h80;
        io_valid_next_pc = 1; io_next_pc = 64'h8000_0300;
        push_ev(cyc, 1'b1, 12'h300, 64'h80, 1'b1, 64'h8000_0300, 1'b0);
        step();
        clr();

        // 4) ebreak + interrupt + xRET request together: exception first,
        //    held interrupt starts at T+5.
        step();
        io_exu_valid = 1; io_is_except = 1; io_exception = 6'd3;
        io_valid_next_pc = 1; io_next_pc = 64'h8000_0900;
        io_irq_valid = 1; io_irq_cause = 6'd11;
        io_pc = 64'h8000_0400; io_mtvec = 64'h8000_2001; io_mstatus = 64'h8;
        t0 = cyc;
        push_trap(t0, 64'h8000_0400, 64'h3, 64'h1880, 64'h8000_2000);
        trap_body();
        step();
        clr();
        io_irq_valid = 1; io_irq_cause = 6'd11;
        io_pc = 64'h8000_0500; io_mtvec = 64'h8000_2001; io_mstatus = 64'h1880;
        check("irq_start_cycle", 64'(cyc), 64'(t0 + 5));
        push_trap(cyc, 64'h8000_0500, 64'h8000_0000_0000_000B, 64'h1800, 64'h8000_202C);
        trap_body();
        step();
        clr();

        // 5) Misaligned pc: low bits of mepc cleared.
        step();
        io_exu_valid = 1; io_is_except = 1; io_exception = 6'd8;
        io_pc = 64'h8000_0106; io_mtvec = 64'h8000_3000; io_mstatus = 64'h0;
        push_trap(cyc, 64'h8000_0104, 64'h8, 64'h1800, 64'h8000_3000);
        trap_body();
        step();
        clr();

        // 6) mtvec mode 2 with an interrupt behaves as direct.
        step();
        io_irq_valid = 1; io_irq_cause = 6'd3;
        io_pc = 64'h8000_0800; io_mtvec = 64'h8000_4002; io_mstatus = 64'h1888;
        push_trap(cyc, 64'h8000_0800, 64'h8000_0000_0000_0003, 64'h1880, 64'h8000_4000);
        step();
        io_irq_valid = 0;
        garbage();
        for (int i = 0; i < 3; i++) begin
            step();
            garbage();
        end
        step();
        clr();

        // 7) Vectored target wraps modulo 2^64.
        step();
        io_irq_valid = 1; io_irq_cause = 6'd7;
        io_pc = 64'h8000_0700; io_mtvec = 64'hFFFF_FFFF_FFFF_FFFD; io_mstatus = 64'h0;
        push_trap(cyc, 64'h8000_0700, 64'h8000_0000_0000_0007, 64'h1800, 64'h18);
        step();
        io_irq_valid = 0;
        for (int i = 0; i < 4; i++) step();
        clr();

        // 8) Reset at T+2 aborts the sequence; pass-through works afterwards.
        step();
        io_exu_valid = 1; io_is_except = 1; io_exception = 6'd11;
        io_pc = 64'h8000_0600; io_mtvec = 64'h8000_5000; io_mstatus = 64'h8;
        t0 = cyc;
        push_ev(t0 + 1, 1'b1, 12'h341, 64'h8000_0600, 1'b0, 64'd0, 1'b1);
        step();
        clr();
        step();
        reset = 1;
        io_exu_valid = 1; io_csr_is_w = 1; io_result_csr_addr = 12'h305;
        io_result_csr_data = 64'h77; io_valid_next_pc = 1; io_next_pc = 64'h1234;
        check_all_zero();
        step();
        check_all_zero();
        step();
        reset = 0;
        clr();
        io_exu_valid = 1; io_csr_is_w = 1; io_result_csr_addr = 12'h340;
        io_result_csr_data = 64'h55;
        push_ev(cyc, 1'b1, 12'h340, 64'h55, 1'b0, 64'd0, 1'b0);
        @(negedge clock);
        check("busy_after_reset", {63'd0, io_busy}, 64'd0);
        step();
        clr();

        // Quiet period: any stray event is flagged by the monitor.
        repeat (8) step();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
